hazard_unit: RTL
================

Name: hazard_unit

Overview:
Responder end of the pipeline hazard interface. The CPU core currently ties that interface off (stallf, FlushE, ForwardAE, ForwardBE).
- Compares register ids across the D/E/M/W stages and drives the stall, flush and forward selects.
- Holds a registered busy counter for multi-cycle ALU operations (mult/div) and a saturating stall-cycle performance counter.
- Sits beside the stage modules inside cpu and replaces the constant assigns there.

Parameters:
MULT_LATENCY, 4, total execute cycles of a multi-cycle op; legal range 1..15; 1 means no extra stall.
COUNT_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
clock  in  1  pipeline clock, rising edge
reset_n  in  1  asynchronous active-low reset
RsD  in  5  rs id in decode
RtD  in  5  rt id in decode
BranchD  in  1  branch/jump resolving in decode (pc_src path)
pc_src_d  in  1  redirect taken this cycle
RsE  in  5  rs id in execute
RtE  in  5  rt id in execute
WriteRegE  in  5  destination id in execute
RegWriteE  in  1  execute writes register file
MemtoRegE  in  1  execute instruction is a load
MultStartE  in  1  multi-cycle op entering execute this cycle
WriteRegM  in  5  destination id in mem
RegWriteM  in  1  mem writes register file
MemtoRegM  in  1  mem instruction is a load
WriteRegW  in  5  destination id in writeback
RegWriteW  in  1  writeback writes register file
stallf  out  1  hold PC, active-high
StallD  out  1  hold fetch pipeline register, active-high
FlushD  out  1  clear fetch pipeline register, active-high
FlushE  out  1  bubble into execute, ACTIVE-LOW (0 = flush), matching the existing execute_stage port
ForwardAE  out  2  ALU A select: 00 register, 01 ResultW, 10 ALUOutM
ForwardBE  out  2  ALU B select, same encoding
ForwardAD  out  1  decode comparator A takes ALUOutM
ForwardBD  out  1  decode comparator B takes ALUOutM
busy  out  1  multi-cycle op in progress
stall_count  out  COUNT_WIDTH  cycles with stallf asserted, saturating

Behaviour:
- Register id 0 never matches in any comparison below.
- ForwardAE (combinational):
  - 10 if RsE==WriteRegM and RegWriteM.
  - else 01 if RsE==WriteRegW and RegWriteW.
  - else 00.
  - M wins over W when both match.
- ForwardBE: same rule using RtE.
- ForwardAD = RsD==WriteRegM and RegWriteM. ForwardBD: same using RtD.
- lwstall = MemtoRegE and RegWriteE and WriteRegE in {RsD, RtD}.
- branchstall = BranchD and (
  - (RegWriteE and WriteRegE in {RsD, RtD}), or
  - (MemtoRegM and WriteRegM in {RsD, RtD}) ).
- Multi-cycle busy counter busy_cnt (4 bits):
  - On a rising edge with MultStartE=1 and busy_cnt==0: load MULT_LATENCY-1.
  - Else if busy_cnt!=0: decrement.
  - MultStartE while busy_cnt!=0 is ignored.
  - busy = (busy_cnt!=0). Stall length after MultStartE is therefore MULT_LATENCY-1 cycles, starting the cycle after MultStartE is sampled.
- Stall = lwstall or branchstall or busy.
- stallf = StallD = Stall.
- FlushE = not (lwstall or branchstall). busy does NOT flush E: the multi-cycle op stays in E.
- FlushD = pc_src_d and not Stall. A stall suppresses the redirect flush for that cycle.
- stall_count: +1 on each rising edge where stallf=1; holds at all-ones (no wrap).
- Reset (reset_n low, asynchronous, any state including mid-multi-cycle op):
  - busy_cnt=0, stall_count=0, busy=0.
  - Outputs forced: stallf=1, StallD=1, FlushE=0 (flush), FlushD=0, all forwards 0.
- After reset_n deasserts, outputs follow the combinational rules in the same cycle.

Decomposition:
- Shared package/header (hazard_defs.vh):
  - forward encodings FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10
  - FLUSH_ACTIVE=1'b0
  - REG_ZERO=5'd0
- One sub-module, multicycle_busy_counter: parameter MULT_LATENCY; ports clock, reset_n, MultStartE, busy.
- Comparison and stall logic stay flat in hazard_unit.

Test Plan:
1. Reset mid-op: MultStartE pulse, then reset_n=0 after 1 cycle -> busy=0, stallf=1, FlushE=0 immediately; after release, stall_count=0 and busy=0.
2. Forward priority: RsE=5, WriteRegM=5, RegWriteM=1, WriteRegW=5, RegWriteW=1 -> ForwardAE=10. Clear RegWriteM -> 01. Set RsE=0 -> 00.
3. Load-use: MemtoRegE=1, RegWriteE=1, WriteRegE=8, RtD=8 -> stallf=1, StallD=1, FlushE=0 for exactly one cycle; stall_count increments by 1.
4. Branch hazard: BranchD=1, RsD=3, MemtoRegM=1, WriteRegM=3, pc_src_d=1 -> stall asserted, FlushD=0. Next cycle with the hazard gone -> FlushD=1.
5. Multi-cycle op: MULT_LATENCY=4, one-cycle MultStartE pulse -> stallf high for exactly 3 cycles, FlushE stays 1. A second MultStartE during busy does not extend the stall.
6. Saturation: COUNT_WIDTH=4, hold a stall for 20 cycles -> stall_count ends at 15, no wrap.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit.
package hazard_unit_pkg;

   // ALU operand forward selects
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   // FlushE is active-low to match the execute stage port
   localparam logic FLUSH_ACTIVE = 1'b0;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Register id match; $zero is hardwired and never creates a dependency
   function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
      return (a == b) && (a != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_unit_multicycle_busy_counter.sv
// Busy counter for multi-cycle execute ops (mult/div). MULT_LATENCY is the
// total execute cycles, legal 1..15; busy covers the MULT_LATENCY-1 extra cycles.
module multicycle_busy_counter #(
   parameter int MULT_LATENCY = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic MultStartE,
   output logic busy
);

   localparam logic [3:0] LOAD_VAL = 4'(MULT_LATENCY - 1);

   logic [3:0] busyCnt;

   // Load on a new op when idle, otherwise count down; starts while busy are ignored
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         busyCnt <= 4'd0;
      else if (MultStartE && (busyCnt == 4'd0))
         busyCnt <= LOAD_VAL;
      else if (busyCnt != 4'd0)
         busyCnt <= busyCnt - 4'd1;
   end

   assign busy = (busyCnt != 4'd0);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding selects, load-use/branch stalls,
// multi-cycle busy stall and a saturating stall-cycle counter.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [4:0]             RsD,
   input  logic [4:0]             RtD,
   input  logic                   BranchD,
   input  logic                   pc_src_d,
   input  logic [4:0]             RsE,
   input  logic [4:0]             RtE,
   input  logic [4:0]             WriteRegE,
   input  logic                   RegWriteE,
   input  logic                   MemtoRegE,
   input  logic                   MultStartE,
   input  logic [4:0]             WriteRegM,
   input  logic                   RegWriteM,
   input  logic                   MemtoRegM,
   input  logic [4:0]             WriteRegW,
   input  logic                   RegWriteW,
   output logic                   stallf,
   output logic                   StallD,
   output logic                   FlushD,
   output logic                   FlushE,
   output logic [1:0]             ForwardAE,
   output logic [1:0]             ForwardBE,
   output logic                   ForwardAD,
   output logic                   ForwardBD,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] stall_count
);

   logic busyRaw;
   logic lwStall;
   logic branchStall;
   logic stall;

   multicycle_busy_counter #(.MULT_LATENCY(MULT_LATENCY)) uBusy (
      .clock      (clock),
      .reset_n    (reset_n),
      .MultStartE (MultStartE),
      .busy       (busyRaw)
   );

   // Hazard detection on register ids across stages
   always_comb begin
      lwStall = MemtoRegE && RegWriteE &&
                (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD));
      branchStall = BranchD && (
                    (RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                    (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));
      stall = lwStall || branchStall || busyRaw;
   end

   // Output drive; while reset is low the pipeline is held and E is flushed
   always_comb begin
      stallf    = 1'b1;
      StallD    = 1'b1;
      FlushD    = 1'b0;
      FlushE    = FLUSH_ACTIVE;
      ForwardAE = FWD_REG;
      ForwardBE = FWD_REG;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      busy      = 1'b0;
      if (reset_n) begin
         stallf = stall;
         StallD = stall;
         // A stall holds D, so a redirect flush that cycle would drop the held instruction
         FlushD = pc_src_d && !stall;
         // busy keeps the multi-cycle op in E, so only data hazards bubble E
         FlushE = (lwStall || branchStall) ? FLUSH_ACTIVE : ~FLUSH_ACTIVE;
         // M is the younger producer, so it wins over W
         if (RegWriteM && regMatch(RsE, WriteRegM))      ForwardAE = FWD_M;
         else if (RegWriteW && regMatch(RsE, WriteRegW)) ForwardAE = FWD_W;
         if (RegWriteM && regMatch(RtE, WriteRegM))      ForwardBE = FWD_M;
         else if (RegWriteW && regMatch(RtE, WriteRegW)) ForwardBE = FWD_W;
         ForwardAD = RegWriteM && regMatch(RsD, WriteRegM);
         ForwardBD = RegWriteM && regMatch(RtD, WriteRegM);
         busy      = busyRaw;
      end
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         stall_count <= '0;
      else if (stallf && (stall_count != {COUNT_WIDTH{1'b1}}))
         stall_count <= stall_count + 1'b1;
   end

endmodule
